c3_custom_simd_instruction: RTL and testbench

C3_CUSTOM_SIMD_INSTRUCTION -- requirements
Module: c3_custom_simd_instruction

---
 rtl/c3_custom_simd_instruction_pkg.sv | 15 +
 rtl/c3_custom_simd_instruction_cmp_swap.sv | 26 ++
 rtl/c3_custom_simd_instruction.sv | 177 +++++++++++++++++
 tb/tb_c3_custom_simd_instruction.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/c3_custom_simd_instruction_pkg.sv
// Shared constants and FSM encoding for the heap-backed custom SIMD instruction.
// Default vector width, heap depth, op-bit position and key width live here.
package c3_custom_simd_instruction_pkg;
  localparam int VLEN   = 256;
  localparam int DEPTH  = 16;
  localparam int OP_BIT = 31;
  localparam int KEY_W  = 31;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    SIFT_UP   = 2'd1,
    SIFT_DOWN = 2'd2,
    DONE      = 2'd3
  } state_t;
endpackage

// File: rtl/c3_custom_simd_instruction_cmp_swap.sv
// Compare-and-swap cell for the heap: decides whether key_b belongs above key_a
// (unsigned, strict less-than, b must be a live entry) and presents swapped keys.
module heap_cmp_swap #(
  parameter int IW = 6,
  parameter int CW = 5,
  parameter int KW = 31
) (
  input  logic [CW-1:0] i_count,
  input  logic [IW-1:0] i_idx_a,
  input  logic [IW-1:0] i_idx_b,
  input  logic [KW-1:0] i_key_a,
  input  logic [KW-1:0] i_key_b,
  output logic          o_lt,
  output logic [IW-1:0] o_sel_idx,
  output logic [KW-1:0] o_key_a,
  output logic [KW-1:0] o_key_b
);
  logic w_b_valid;

  assign w_b_valid = i_idx_b < IW'(i_count);
  // Equal keys never report less-than, so ties never swap.
  assign o_lt      = w_b_valid && (i_key_b < i_key_a);
  assign o_sel_idx = o_lt ? i_idx_b : i_idx_a;
  assign o_key_a   = i_key_b;
  assign o_key_b   = i_key_a;
endmodule

// File: rtl/c3_custom_simd_instruction.sv
// Min-heap priority queue exposed as a custom instruction: push/pop of 31-bit keys,
// one heap level per cycle, with tags and vector operands carried to completion.
module c3_custom_simd_instruction
  import c3_custom_simd_instruction_pkg::state_t,
         c3_custom_simd_instruction_pkg::IDLE,
         c3_custom_simd_instruction_pkg::SIFT_UP,
         c3_custom_simd_instruction_pkg::SIFT_DOWN,
         c3_custom_simd_instruction_pkg::DONE,
         c3_custom_simd_instruction_pkg::OP_BIT,
         c3_custom_simd_instruction_pkg::KEY_W;
#(
  parameter int VLEN  = c3_custom_simd_instruction_pkg::VLEN,
  parameter int DEPTH = c3_custom_simd_instruction_pkg::DEPTH
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_v,
  input  logic [4:0]      rd,
  input  logic [2:0]      vrd1,
  input  logic [2:0]      vrd2,
  input  logic [31:0]     in_data,
  input  logic [VLEN-1:0] in_vdata1,
  input  logic [VLEN-1:0] in_vdata2,
  output logic            out_v,
  output logic [4:0]      out_rd,
  output logic [2:0]      out_vrd1,
  output logic [2:0]      out_vrd2,
  output logic [31:0]     out_data,
  output logic [VLEN-1:0] out_vdata1,
  output logic [VLEN-1:0] out_vdata2
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int IW = AW + 2;

  state_t            state, w_state_next;
  logic [KEY_W-1:0]  r_heap [DEPTH];
  logic [CW-1:0]     r_count;
  logic [IW-1:0]     r_cursor;
  logic              r_is_pop;
  logic [KEY_W-1:0]  r_result;
  logic [4:0]        r_rd;
  logic [2:0]        r_vrd1, r_vrd2;
  logic [VLEN-1:0]   r_vd1, r_vd2;

  logic              w_op, w_full, w_empty, w_accept;
  logic [KEY_W-1:0]  w_key;
  logic [CW-1:0]     w_last;
  logic [IW-1:0]     w_left, w_right, w_parent, w_child;
  logic [IW-1:0]     w_cmp_idx_a, w_cmp_idx_b, w_sel_idx;
  logic [KEY_W-1:0]  w_new_a, w_new_b;
  logic              w_lt, w_swap;

  // Indices past the array read as zero; callers gate them with the count.
  function automatic logic [KEY_W-1:0] heap_at(input logic [IW-1:0] idx);
    if (idx < IW'(DEPTH)) return r_heap[idx[AW-1:0]];
    return '0;
  endfunction

  assign w_op     = in_data[OP_BIT];
  assign w_key    = in_data[KEY_W-1:0];
  assign w_full   = r_count == CW'(DEPTH);
  assign w_empty  = r_count == '0;
  assign w_accept = (state == IDLE) && in_v;
  assign w_last   = r_count - CW'(1);

  assign w_left   = {r_cursor[IW-2:0], 1'b0} + IW'(1);
  assign w_right  = {r_cursor[IW-2:0], 1'b0} + IW'(2);
  assign w_parent = (r_cursor - IW'(1)) >> 1;
  // Right child wins only when live and strictly smaller; ties go left.
  assign w_child  = ((w_right < IW'(r_count)) && (heap_at(w_right) < heap_at(w_left)))
                    ? w_right : w_left;

  assign w_cmp_idx_a = (state == SIFT_UP) ? w_parent : r_cursor;
  assign w_cmp_idx_b = (state == SIFT_UP) ? r_cursor : w_child;

  heap_cmp_swap #(.IW(IW), .CW(CW), .KW(KEY_W)) u_cmp (
    .i_count   (r_count),
    .i_idx_a   (w_cmp_idx_a),
    .i_idx_b   (w_cmp_idx_b),
    .i_key_a   (heap_at(w_cmp_idx_a)),
    .i_key_b   (heap_at(w_cmp_idx_b)),
    .o_lt      (w_lt),
    .o_sel_idx (w_sel_idx),
    .o_key_a   (w_new_a),
    .o_key_b   (w_new_b)
  );

  assign w_swap = ((state == SIFT_UP) && (r_cursor != '0) && w_lt) ||
                  ((state == SIFT_DOWN) && w_lt);

  always_comb begin
    w_state_next = state;
    case (state)
      IDLE: begin
        if (in_v) begin
          if (!w_op) w_state_next = w_full  ? DONE : SIFT_UP;
          else       w_state_next = w_empty ? DONE : SIFT_DOWN;
        end
      end
      SIFT_UP:   if (!w_swap) w_state_next = DONE;
      SIFT_DOWN: if (!w_swap) w_state_next = DONE;
      DONE:      w_state_next = IDLE;
      default:   w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= w_state_next;
  end

  assign out_v = (state == DONE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) r_heap[i] <= '0;
      r_count    <= '0;
      r_cursor   <= '0;
      r_is_pop   <= 1'b0;
      r_result   <= '0;
      r_rd       <= '0;
      r_vrd1     <= '0;
      r_vrd2     <= '0;
      r_vd1      <= '0;
      r_vd2      <= '0;
      out_rd     <= '0;
      out_vrd1   <= '0;
      out_vrd2   <= '0;
      out_data   <= '0;
      out_vdata1 <= '0;
      out_vdata2 <= '0;
    end else begin
      if (w_accept) begin
        r_is_pop <= w_op;
        r_rd     <= rd;
        r_vrd1   <= vrd1;
        r_vrd2   <= vrd2;
        r_vd1    <= in_vdata1;
        r_vd2    <= in_vdata2;
        if (!w_op && !w_full) begin
          r_heap[r_count[AW-1:0]] <= w_key;
          r_count  <= r_count + CW'(1);
          r_cursor <= IW'(r_count);
        end else if (w_op && !w_empty) begin
          r_result  <= r_heap[0];
          r_heap[0] <= r_heap[w_last[AW-1:0]];
          r_count   <= w_last;
          r_cursor  <= '0;
        end
      end else if (w_swap) begin
        r_heap[w_cmp_idx_a[AW-1:0]] <= w_new_a;
        r_heap[w_cmp_idx_b[AW-1:0]] <= w_new_b;
        r_cursor <= (state == SIFT_UP) ? w_parent : w_sel_idx;
      end

      // Outputs change only on entry to DONE so they hold between completions.
      if ((w_state_next == DONE) && (state != DONE)) begin
        if (state == IDLE) begin
          out_rd     <= '0;
          out_vrd1   <= vrd1;
          out_vrd2   <= vrd2;
          out_vdata1 <= in_vdata1;
          out_vdata2 <= in_vdata2;
          out_data   <= w_op ? 32'd0 : 32'(DEPTH);
        end else begin
          out_rd     <= r_rd;
          out_vrd1   <= r_vrd1;
          out_vrd2   <= r_vrd2;
          out_vdata1 <= r_vd1;
          out_vdata2 <= r_vd2;
          out_data   <= r_is_pop ? {1'b0, r_result} : 32'(r_count);
        end
      end
    end
  end
endmodule

// File: tb/tb_c3_custom_simd_instruction.sv
// Randomized bench for the heap instruction: a multiset model predicts every result.
module tb_c3_custom_simd_instruction;
  import c3_custom_simd_instruction_pkg::*;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             in_v = 1'b0;
  logic [4:0]       rd = '0;
  logic [2:0]       vrd1 = '0, vrd2 = '0;
  logic [31:0]      in_data = '0;
  logic [VLEN-1:0]  in_vdata1 = '0, in_vdata2 = '0;
  logic             out_v;
  logic [4:0]       out_rd;
  logic [2:0]       out_vrd1, out_vrd2;
  logic [31:0]      out_data;
  logic [VLEN-1:0]  out_vdata1, out_vdata2;

  int               n_vec = 0;
  int               n_err = 0;
  logic [30:0]      model_q[$];
  logic [31:0]      exp_q[$];

  bit               got_seen;
  int               got_lat;
  logic [31:0]      got_data;
  logic [4:0]       got_rd;
  logic [2:0]       got_vrd1, got_vrd2;
  logic [VLEN-1:0]  got_vd1, got_vd2;

  c3_custom_simd_instruction #(.VLEN(VLEN), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_v       (in_v),
    .rd         (rd),
    .vrd1       (vrd1),
    .vrd2       (vrd2),
    .in_data    (in_data),
    .in_vdata1  (in_vdata1),
    .in_vdata2  (in_vdata2),
    .out_v      (out_v),
    .out_rd     (out_rd),
    .out_vrd1   (out_vrd1),
    .out_vrd2   (out_vrd2),
    .out_data   (out_data),
    .out_vdata1 (out_vdata1),
    .out_vdata2 (out_vdata2)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic apply_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    model_q.delete();
    exp_q.delete();
  endtask

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // driver: one instruction, then wait (bounded) for its completion pulse
  task automatic run_op(input bit op, input logic [30:0] key, input logic [4:0] t_rd,
                        input logic [2:0] t_v1, input logic [2:0] t_v2,
                        input logic [VLEN-1:0] d1, input logic [VLEN-1:0] d2, input bit hold_v);
    @(negedge clk);
    in_v = 1'b1; in_data = {op, key}; rd = t_rd; vrd1 = t_v1; vrd2 = t_v2;
    in_vdata1 = d1; in_vdata2 = d2;
    @(posedge clk); #1;
    if (!hold_v) in_v = 1'b0;
    else begin
      in_data = ~in_data; rd = ~t_rd; in_vdata1 = ~d1;
    end
    got_seen = 1'b0; got_lat = 0;
    for (int c = 0; c <= 12 && !got_seen; c++) begin
      if (c > 0) begin @(posedge clk); #1; end
      if (out_v) begin
        got_seen = 1'b1; got_lat = c;
        got_data = out_data; got_rd = out_rd; got_vrd1 = out_vrd1; got_vrd2 = out_vrd2;
        got_vd1 = out_vdata1; got_vd2 = out_vdata2;
      end
    end
    in_v = 1'b0;
    if (got_seen) begin
      @(posedge clk); #1;
      check("pulse_width", out_v, 1'b0);
    end
  endtask

  // scoreboard: model predicts, driver executes, results compared
  task automatic do_op(input bit op, input logic [30:0] key, input logic [4:0] t_rd,
                       input logic [2:0] t_v1, input logic [2:0] t_v2,
                       input logic [VLEN-1:0] d1, input logic [VLEN-1:0] d2, input bit hold_v);
    logic [31:0] e_data;
    logic [4:0]  e_rd;
    int          mi;
    if (!op) begin
      if (model_q.size() == DEPTH) begin
        e_rd = '0; e_data = DEPTH;
      end else begin
        model_q.push_back(key);
        e_rd = t_rd; e_data = model_q.size();
      end
    end else if (model_q.size() == 0) begin
      e_rd = '0; e_data = '0;
    end else begin
      mi = 0;
      for (int i = 1; i < model_q.size(); i++) if (model_q[i] < model_q[mi]) mi = i;
      e_data = {1'b0, model_q[mi]};
      model_q.delete(mi);
      e_rd = t_rd;
    end
    exp_q.push_back(e_data);
    run_op(op, key, t_rd, t_v1, t_v2, d1, d2, hold_v);
    check("completion_seen", got_seen, 1'b1);
    e_data = exp_q.pop_front();
    check(op ? "pop_data" : "push_data", got_data, e_data);
    check("out_rd", got_rd, e_rd);
    check("out_vrd1", got_vrd1, t_v1);
    check("out_vrd2", got_vrd2, t_v2);
    check("out_vdata1", got_vd1, d1);
    check("out_vdata2", got_vd2, d2);
    check("count", dut.r_count, model_q.size());
  endtask

  task automatic quick(input bit op, input logic [30:0] key);
    do_op(op, key, 5'd9, 3'd1, 3'd2, {8{$urandom}}, {8{$urandom}}, 1'b0);
  endtask

  initial begin
    logic [VLEN-1:0] pat_a5;
    logic [31:0]     prev;
    bit              saw_v;
    int              k5[4];
    pat_a5 = {32{8'hA5}};
    k5 = '{5, 3, 8, 1};

    apply_reset();
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_v", out_v, 1'b0);
    check("rst_count", dut.r_count, 0);
    check("rst_state", dut.state, IDLE);
    check("rst_out_data", out_data, 0);
    check("rst_out_rd", out_rd, 0);
    check("rst_out_vdata1", out_vdata1, 0);

    // directed push/pop ordering
    foreach (k5[i]) quick(1'b0, 31'(k5[i]));
    for (int i = 0; i < 4; i++) quick(1'b1, '0);

    // fill, overflow, drain in sorted order
    for (int i = 0; i < DEPTH; i++) quick(1'b0, 31'($urandom_range(0, 255)));
    do_op(1'b0, 31'd77, 5'd12, 3'd4, 3'd5, '1, '0, 1'b0);
    prev = '0;
    for (int i = 0; i < DEPTH; i++) begin
      quick(1'b1, '0);
      check("nondecreasing", got_data >= prev, 1'b1);
      prev = got_data;
    end

    // empty pop
    do_op(1'b1, '0, 5'd7, 3'd0, 3'd0, '0, '0, 1'b0);
    check("empty_count", dut.r_count, 0);

    // sift-up latency with in_v held while busy
    quick(1'b0, 31'd1); quick(1'b0, 31'd2); quick(1'b0, 31'd3);
    do_op(1'b0, 31'd0, 5'd4, 3'd3, 3'd6, pat_a5, pat_a5, 1'b1);
    check("latency_2swap", got_lat, 3);
    for (int i = 0; i < 4; i++) quick(1'b1, '0);

    // vector pass-through
    do_op(1'b0, 31'd42, 5'd1, 3'd3, 3'd7, pat_a5, ~pat_a5, 1'b0);
    quick(1'b1, '0);

    // randomized mix with full-range keys
    for (int i = 0; i < 120; i++) begin
      do_op($urandom_range(0, 99) < 55 ? 1'b0 : 1'b1, 31'($urandom),
            5'($urandom_range(1, 31)), 3'($urandom), 3'($urandom),
            {8{$urandom}}, {8{$urandom}}, 1'($urandom));
      check("latency_bound", got_lat <= 5, 1'b1);
    end

    // reset during SIFT_UP aborts the op
    apply_reset();
    quick(1'b0, 31'd10); quick(1'b0, 31'd20); quick(1'b0, 31'd30);
    @(negedge clk);
    in_v = 1'b1; in_data = {1'b0, 31'd0}; rd = 5'd5;
    @(posedge clk); #1;
    in_v = 1'b0;
    check("abort_in_sift_up", dut.state, SIFT_UP);
    reset = 1'b1;
    #1;
    check("abort_state", dut.state, IDLE);
    check("abort_count", dut.r_count, 0);
    check("abort_heap0", dut.r_heap[0], 0);
    check("abort_out_v", out_v, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    model_q.delete();
    saw_v = 1'b0;
    repeat (6) begin
      @(posedge clk); #1;
      if (out_v) saw_v = 1'b1;
    end
    check("abort_no_out_v", saw_v, 1'b0);
    quick(1'b0, 31'd6);
    quick(1'b1, '0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
